// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode bytes from a UART receiver, runs them through an external ALU and sends the result byte back.
// Optional inter-byte timeout: define UART_IF_TIMEOUT_EN.
module uart_alu_interface #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_tx_done,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_overrun,
  output logic                  o_timeout
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t state, state_next;
  logic   timeout_hit;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= WAIT_A;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_A:  if (i_rx_done) state_next = WAIT_B;
      WAIT_B:  if (i_rx_done) state_next = WAIT_OP;
               else if (timeout_hit) state_next = WAIT_A;
      WAIT_OP: if (i_rx_done) state_next = EXEC;
               else if (timeout_hit) state_next = WAIT_A;
      EXEC:    state_next = SEND;
      SEND:    state_next = WAIT_TX;
      WAIT_TX: if (i_tx_done) state_next = WAIT_A;
      default: state_next = WAIT_A;
    endcase
  end

  always_comb begin
    o_tx_start = (state == SEND);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (i_rx_done) begin
        case (state)
          WAIT_A: begin
            o_alu_a   <= i_rx_data;
            o_overrun <= 1'b0;
          end
          WAIT_B:  o_alu_b  <= i_rx_data;
          WAIT_OP: o_alu_op <= i_rx_data[OP_WIDTH-1:0];
          default: o_overrun <= 1'b1;
        endcase
      end
      if (state == EXEC) o_tx_data <= i_alu_result;
    end
  end

`ifdef UART_IF_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;
  logic             waiting;

  always_comb begin
    waiting     = (state == WAIT_B) || (state == WAIT_OP);
    // A byte arriving on the terminal count wins over the timeout.
    timeout_hit = waiting && !i_rx_done && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt       <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= timeout_hit;
      if (waiting && !i_rx_done && (state_next == state)) cnt <= cnt + 1'b1;
      else                                                 cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

endmodule
